// File: rtl/tile_pkg.sv
// Shared types and constants for the white-tile game controller.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0] ROW_TOP = 4'd8;
  localparam logic [3:0] ROW_MID = 4'd4;
  localparam logic [3:0] ROW_BOT = 4'd0;
  localparam logic [3:0] NO_TILE = 4'hF;

  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] row_addr(input logic [3:0] base, input logic [1:0] col);
    return base + {2'b00, col};
  endfunction

endpackage

// File: rtl/tile_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts every cycle, seeded on reset.
module tile_lfsr16
  import tile_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) value <= SEED;
    else     value <= lfsr_next(value);
  end

endmodule

// File: rtl/tile_game_ctrl.sv
// Game sequencer for the white-tile display: key decode, hit check,
// row scrolling, score and a per-step timeout that tightens with score.
module tile_game_ctrl
  import tile_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned TIMEOUT_INIT  = 50_000_000,
  parameter int unsigned TIMEOUT_STEP  = 2_500_000,
  parameter int unsigned TIMEOUT_MIN   = 10_000_000,
  parameter int unsigned SPEEDUP_EVERY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        start,
  output logic [11:0] pos,
  output logic [15:0] score,
  output logic        playing,
  output logic        game_over,
  output logic        hit
);

  // Handshake note: there is no valid/ready traffic here; key and start are
  // asynchronous levels, and only their synchronised rising edges act.
  logic [3:0] key_s1, key_s2, key_prev;
  logic       start_s1, start_s2, start_prev;
  logic [3:0] key_ev;
  logic       start_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1     <= '0;
      key_s2     <= '0;
      key_prev   <= '0;
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      key_s1     <= key;
      key_s2     <= key_s1;
      key_prev   <= key_s2;
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
    end
  end

  assign key_ev   = key_s2 & ~key_prev;
  assign start_ev = start_s2 & ~start_prev;

  logic [15:0] lfsr;

  tile_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  state_t      state, state_nx;
  logic [1:0]  top_col, mid_col, bot_col;
  logic [1:0]  top_nx, mid_nx, bot_nx;
  logic [15:0] score_nx;
  logic [31:0] limit, limit_nx;
  logic [31:0] timer, timer_nx;
  logic        hit_nx;

  logic [15:0] score_inc;
  logic [1:0]  new_top;
  logic [31:0] faster_limit;
  logic        multi_ev;
  logic        speedup;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      top_col <= 2'd0;
      mid_col <= 2'd0;
      bot_col <= 2'd0;
      score   <= 16'd0;
      limit   <= TIMEOUT_INIT;
      timer   <= 32'd0;
      hit     <= 1'b0;
    end else begin
      state   <= state_nx;
      top_col <= top_nx;
      mid_col <= mid_nx;
      bot_col <= bot_nx;
      score   <= score_nx;
      limit   <= limit_nx;
      timer   <= timer_nx;
      hit     <= hit_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    top_nx    = top_col;
    mid_nx    = mid_col;
    bot_nx    = bot_col;
    score_nx  = score;
    limit_nx  = limit;
    timer_nx  = timer;
    hit_nx    = 1'b0;

    multi_ev  = (key_ev & (key_ev - 4'd1)) != 4'd0;
    score_inc = (score == 16'hFFFF) ? score : score + 16'd1;
    // The fresh top tile must never stack onto the column it scrolls away from.
    new_top   = (lfsr[1:0] == top_col) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
    // Comparing against STEP+MIN keeps the subtraction from ever underflowing.
    faster_limit = (limit >= TIMEOUT_STEP + TIMEOUT_MIN) ? limit - TIMEOUT_STEP
                                                         : TIMEOUT_MIN;
    speedup   = (score_inc != 16'd0) &&
                (({16'd0, score_inc} % SPEEDUP_EVERY) == 32'd0);

    case (state)
      IDLE, OVER: begin
        if (start_ev) begin
          state_nx = PLAY;
          bot_nx   = lfsr[1:0];
          mid_nx   = lfsr[3:2];
          top_nx   = lfsr[5:4];
          score_nx = 16'd0;
          limit_nx = TIMEOUT_INIT;
          timer_nx = TIMEOUT_INIT;
        end
      end
      PLAY: begin
        if (multi_ev) begin
          state_nx = OVER;
        end else if (key_ev == (4'b0001 << bot_col)) begin
          bot_nx   = mid_col;
          mid_nx   = top_col;
          top_nx   = new_top;
          score_nx = score_inc;
          hit_nx   = 1'b1;
          if (speedup) limit_nx = faster_limit;
          timer_nx = speedup ? faster_limit : limit;
        end else if (key_ev != 4'd0) begin
          state_nx = OVER;
        end else if (timer <= 32'd1) begin
          state_nx = OVER;
        end else begin
          timer_nx = timer - 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pos = (state == IDLE) ? {NO_TILE, NO_TILE, NO_TILE}
                               : {row_addr(ROW_TOP, top_col),
                                  row_addr(ROW_MID, mid_col),
                                  row_addr(ROW_BOT, bot_col)};
  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Directed bench for tile_game_ctrl with a shortened timeout schedule.
module tb_tile_game_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst;
  logic [3:0]  key;
  logic        start;
  logic [11:0] pos;
  logic [15:0] score;
  logic        playing;
  logic        game_over;
  logic        hit;

  tile_game_ctrl #(
    .LFSR_SEED     (SEED),
    .TIMEOUT_INIT  (20),
    .TIMEOUT_STEP  (5),
    .TIMEOUT_MIN   (10),
    .SPEEDUP_EVERY (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .start     (start),
    .pos       (pos),
    .score     (score),
    .playing   (playing),
    .game_over (game_over),
    .hit       (hit)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent LFSR model; lfsr_last is the value the DUT saw before the latest edge.
  logic [15:0] lfsr_m, lfsr_last;
  always @(posedge clk) begin
    if (rst) lfsr_m <= SEED;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    lfsr_last <= lfsr_m;
  end

  // Scoreboard
  int tests_run    = 0;
  int tests_failed = 0;
  logic [1:0]  eb, em, et;
  logic [15:0] escore;
  logic [31:0] hit_limit [6] = '{32'd20, 32'd15, 32'd15, 32'd10, 32'd10, 32'd10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pack(input logic [1:0] t, input logic [1:0] m,
                                       input logic [1:0] b);
    logic [3:0] tn, mn;
    tn = 4'd8 + {2'b00, t};
    mn = 4'd4 + {2'b00, m};
    return {tn, mn, 2'b00, b};
  endfunction

  // Drivers: every task returns at the falling edge after the third rising edge.
  task automatic pulse(input logic s, input logic [3:0] k);
    @(negedge clk);
    start = s;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    key   = 4'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] k);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(negedge clk);
    start = 1'b0;
    key   = 4'd0;
    @(negedge clk);
    check("pre_entry_playing", {31'd0, playing}, 32'd0);
    @(negedge clk);
    eb = lfsr_last[1:0];
    em = lfsr_last[3:2];
    et = lfsr_last[5:4];
    escore = 16'd0;
    check("entry_pos", {20'd0, pos}, {20'd0, pack(et, em, eb)});
    check("entry_score", {16'd0, score}, 32'd0);
    check("entry_playing", {31'd0, playing}, 32'd1);
    check("entry_over", {31'd0, game_over}, 32'd0);
    check("entry_timer", dut.timer, 32'd20);
  endtask

  task automatic do_hit(input logic [31:0] exp_lim);
    logic [1:0] nt;
    pulse(1'b0, 4'b0001 << eb);
    nt = (lfsr_last[1:0] == et) ? lfsr_last[1:0] + 2'd1 : lfsr_last[1:0];
    eb = em;
    em = et;
    et = nt;
    escore = escore + 16'd1;
    check("hit_pos", {20'd0, pos}, {20'd0, pack(et, em, eb)});
    check("hit_score", {16'd0, score}, {16'd0, escore});
    check("hit_pulse", {31'd0, hit}, 32'd1);
    check("hit_reload", dut.timer, exp_lim);
    @(negedge clk);
    check("hit_clear", {31'd0, hit}, 32'd0);
  endtask

  initial begin
    int cycles;
    rst   = 1'b1;
    key   = 4'd0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos", {20'd0, pos}, 32'hFFF);
    check("rst_score", {16'd0, score}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_over", {31'd0, game_over}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    rst = 1'b0;

    // Key presses in IDLE are ignored.
    pulse(1'b0, 4'b0010);
    check("idle_key_pos", {20'd0, pos}, 32'hFFF);
    check("idle_key_playing", {31'd0, playing}, 32'd0);

    // Game 1: six hits exercising the speed-up schedule, then a wrong key.
    do_start(4'd0);
    for (int i = 0; i < 6; i++) do_hit(hit_limit[i]);
    pulse(1'b0, 4'b0001 << (eb + 2'd1));
    check("miss_over", {31'd0, game_over}, 32'd1);
    check("miss_playing", {31'd0, playing}, 32'd0);
    check("miss_pos", {20'd0, pos}, {20'd0, pack(et, em, eb)});
    check("miss_score", {16'd0, score}, 32'd6);
    pulse(1'b0, 4'b0001 << eb);
    check("over_key_pos", {20'd0, pos}, {20'd0, pack(et, em, eb)});
    check("over_key_score", {16'd0, score}, 32'd6);
    check("over_key_hit", {31'd0, hit}, 32'd0);
    check("over_key_state", {31'd0, game_over}, 32'd1);

    // Game 2: no presses, timeout after exactly 20 cycles.
    do_start(4'd0);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (game_over) break;
    end
    check("timeout_over", {31'd0, game_over}, 32'd1);
    check("timeout_cycles", cycles, 32'd20);

    // Game 3: two keys in one cycle, one correct.
    do_start(4'd0);
    pulse(1'b0, (4'b0001 << eb) | (4'b0001 << (eb + 2'd1)));
    check("double_over", {31'd0, game_over}, 32'd1);
    check("double_score", {16'd0, score}, 32'd0);

    // Game 4: start and a key together in OVER -> start wins; five hits; then rst.
    do_start(4'b0101);
    for (int i = 0; i < 5; i++) do_hit(hit_limit[i]);
    check("pre_rst_score", {16'd0, score}, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pos", {20'd0, pos}, 32'hFFF);
    check("midrst_score", {16'd0, score}, 32'd0);
    check("midrst_state", {30'd0, dut.state}, 32'd0);
    check("midrst_lfsr", {16'd0, dut.lfsr}, {16'd0, SEED});
    check("midrst_playing", {31'd0, playing}, 32'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
